// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the scanned 7-segment display driver:
//   - active-high segment patterns {a,b,c,d,e,f,g} for digits 0-9, dash and blank
//   - conversion FSM state type
//   - digit_to_pattern(): BCD nibble -> active-high segment pattern
//   - max_decimal(): 10^digits - 1, used to flag values that do not fit the display
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    IDLE,
    CONV
  } conv_state_t;

  // Nibbles 10..15 never come out of a valid BCD conversion; show them blank.
  function automatic logic [6:0] digit_to_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  // Largest value representable on 'digits' decimal digits (64 bits covers 8 digits).
  function automatic logic [63:0] max_decimal(input int digits);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < digits; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if
//   Value-load handshake between the counter logic and the display driver.
//   load     : request to display 'value' (sampled on rising clk)
//   value    : unsigned binary value, DATA_W bits
//   busy     : conversion in progress, load ignored while high
//   overflow : value on display did not fit the digit count
//   master modport: the producer of values; slave modport: the display driver.
interface seg7_scan_display_if #(
  parameter int DATA_W = 14
);
  logic              load;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              overflow;

  modport master (output load, output value, input busy, input overflow);
  modport slave  (input load, input value, output busy, output overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble binary -> BCD converter, one bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin conversion of bin_in (ignored while busy)
//   bin_in     : binary input, DATA_W bits
//   busy       : high for exactly DATA_W cycles after start is accepted
//   done       : high during the final step; bcd is valid alongside it and
//                must be captured at the same edge that ends busy
//   bcd        : DIGITS BCD nibbles (value modulo 10^DIGITS)
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  conv_state_t       state_reg, state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [BCD_W-1:0]  bcd_reg;
  logic [BCD_W-1:0]  bcd_next;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_reg;
  logic              last_step;

  assign last_step = (cnt_reg == '0);

  // Add-3 correction on every nibble that would reach 10 or more after the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  (bcd_reg[4*gi +: 4] + 4'd3) : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Nibbles that shift out of the top are lost; the caller flags that case
  // separately, so truncation here is harmless.
  assign bcd_next = {bcd_adj[BCD_W-2:0], shift_reg[DATA_W-1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)     state_next = CONV;
      CONV:    if (last_step) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == IDLE) begin
      if (start) begin
        shift_reg <= bin_in;
        bcd_reg   <= '0;
        cnt_reg   <= CNT_W'(DATA_W - 1);
      end
    end else begin
      shift_reg <= shift_reg << 1;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_reg - 1'b1;
    end
  end

  assign busy = (state_reg == CONV);
  assign done = busy && last_step;
  assign bcd  = bcd_next;

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Multi-digit time-multiplexed 7-segment driver. A loaded binary value is
//   converted to BCD (bin2bcd_seq) and committed to the display register; a
//   prescaler steps through the digits, SCAN_DIV clocks each.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   host  : load/value/busy/overflow handshake (slave side)
//   an    : one-hot digit enable, registered (active-low when ACTIVE_LOW=1)
//   seg   : {a..g} of the enabled digit, registered (active-low when ACTIVE_LOW=1)
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int DATA_W        = 14,
  parameter int SCAN_DIV      = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_display_if.slave  host,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg
);

  localparam int               BCD_W    = 4 * DIGITS;
  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int               PS_W     = $clog2(SCAN_DIV);
  localparam logic [63:0]      MAX_VAL  = max_decimal(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [DIGITS-1:0] AN_DIG0 = DIGITS'(1);
  localparam logic [DIGITS-1:0] AN_RST  = (ACTIVE_LOW != 0) ? ~AN_DIG0 : AN_DIG0;
  localparam logic [6:0]        SEG_RST = (ACTIVE_LOW != 0) ? ~SEG_0 : SEG_0;

  // Conversion
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             accept;
  logic             ovf_pend_reg;

  // Display state
  logic [BCD_W-1:0] disp_reg, disp_next;
  logic             overflow_reg, overflow_next;

  // Scan
  logic [PS_W-1:0]   ps_reg, ps_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              scan_tc;
  logic [6:0]        pat [DIGITS];
  logic [DIGITS-1:0] an_onehot;
  logic [6:0]        seg_sel;
  logic [DIGITS-1:0] an_reg;
  logic [6:0]        seg_reg;

  assign accept = host.load && !conv_busy;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (host.load),
    .bin_in (host.value),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  // Overflow is decided on the raw binary value; the BCD result is then
  // irrelevant because the whole display shows dashes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend_reg <= 1'b0;
    end else if (accept) begin
      ovf_pend_reg <= (64'(host.value) > MAX_VAL);
    end
  end

  // Commit happens on the same edge as the last conversion step, so the
  // next-state view is what the output registers decode.
  assign disp_next     = conv_done ? conv_bcd     : disp_reg;
  assign overflow_next = conv_done ? ovf_pend_reg : overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      disp_reg     <= disp_next;
      overflow_reg <= overflow_next;
    end
  end

  assign scan_tc = (ps_reg == PS_LAST);

  always_comb begin
    ps_next  = ps_reg + 1'b1;
    idx_next = idx_reg;
    if (scan_tc) begin
      ps_next  = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_reg  <= '0;
      idx_reg <= '0;
    end else begin
      ps_reg  <= ps_next;
      idx_reg <= idx_next;
    end
  end

  // Per-digit pattern. A digit is a leading zero when it and every digit
  // above it are zero; digit 0 is never blanked so a value of 0 shows "0".
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      logic       nonzero_upper;
      logic       blank;

      assign nib           = disp_next[4*gi +: 4];
      assign nonzero_upper = |disp_next[BCD_W-1:4*gi];
      if (gi == 0 || BLANK_LEADING == 0) begin : g_noblank
        assign blank = 1'b0;
      end else begin : g_blank
        assign blank = !nonzero_upper;
      end

      assign pat[gi]       = overflow_next ? SEG_DASH :
                             blank         ? SEG_BLANK : digit_to_pattern(nib);
      assign an_onehot[gi] = (idx_next == IDX_W'(gi));
    end
  endgenerate

  assign seg_sel = pat[idx_next];

  // Registered outputs: they only move when idx or the display register moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= AN_RST;
      seg_reg <= SEG_RST;
    end else begin
      an_reg  <= (ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
      seg_reg <= (ACTIVE_LOW != 0) ? ~seg_sel   : seg_sel;
    end
  end

  assign an            = an_reg;
  assign seg           = seg_reg;
  assign host.busy     = conv_busy;
  assign host.overflow = overflow_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  localparam int DIGITS   = 4;
  localparam int DATA_W   = 14;
  localparam int SCAN_DIV = 4;
  localparam int CONV_LEN = DATA_W;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  typedef struct packed {
    logic            ovf;
    logic [3:0][6:0] segs;   // pin-level (active-low) expected pattern per digit
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DIGITS-1:0] an;
  logic [6:0] seg;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  // Active-high abcdefg reference patterns
  logic [6:0] pat_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  seg7_scan_display_if #(.DATA_W(DATA_W)) host_if ();

  seg7_scan_display #(
    .DIGITS        (DIGITS),
    .DATA_W        (DATA_W),
    .SCAN_DIV      (SCAN_DIV),
    .ACTIVE_LOW    (1),
    .BLANK_LEADING (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host_if),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int v);
    exp_t e;
    int dig [4];
    int x;
    int top;
    x = v;
    top = 0;
    for (int d = 0; d < 4; d++) begin
      dig[d] = x % 10;
      x = x / 10;
      if (dig[d] != 0) top = d;
    end
    e.ovf = (v > 9999);
    for (int d = 0; d < 4; d++) begin
      if (e.ovf)                  e.segs[d] = ~7'b0000001;
      else if (d > top && d != 0) e.segs[d] = ~7'b0000000;
      else                        e.segs[d] = ~pat_tab[dig[d]];
    end
    return e;
  endfunction

  // Load a value at the next negedge, push its expectation and count busy cycles.
  task automatic do_load(input int v, output int n);
    @(negedge clk);
    host_if.load  = 1'b1;
    host_if.value = DATA_W'(v);
    sb_q.push_back(model(v));
    @(negedge clk);
    host_if.load = 1'b0;
    n = 0;
    while (host_if.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    $display("load %0d: busy %0d cycles, overflow=%0b", v, n, host_if.overflow);
  endtask

  // Collect one full frame: the pattern seen on each digit, plus a count of
  // samples where 'an' was not a single enabled digit.
  task automatic capture_frame(output logic [3:0][6:0] segs, output int bad);
    segs = 'x;
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      case (an)
        4'b1110: segs[0] = seg;
        4'b1101: segs[1] = seg;
        4'b1011: segs[2] = seg;
        4'b0111: segs[3] = seg;
        default: bad++;
      endcase
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    host_if.load  = 1'b0;
    host_if.value = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (host_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", host_if.busy); end
    n_checks++; if (host_if.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", host_if.overflow); end
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b want 1110", an); end
    n_checks++; if (seg !== 7'b0000001) begin n_fail++; $display("FAIL reset_seg: got %b want 0000001", seg); end
    sb_q.push_back(model(0));
    rst_n = 1'b1;
    $display("reset released");
  endtask

  // Starts on the negedge where reset was released: digit 0 owns the first SCAN_DIV samples.
  task automatic test_scan();
    exp_t e;
    logic [3:0] an_exp;
    e = sb_q.pop_front();
    for (int i = 0; i < 2 * FRAME; i++) begin
      an_exp = ~(4'b0001 << ((i / SCAN_DIV) % DIGITS));
      n_checks++; if (an !== an_exp) begin n_fail++; $display("FAIL scan_an[%0d]: got %b want %b", i, an, an_exp); end
      n_checks++; if (seg !== e.segs[(i / SCAN_DIV) % DIGITS]) begin
        n_fail++; $display("FAIL scan_seg[%0d]: got %b want %b", i, seg, e.segs[(i / SCAN_DIV) % DIGITS]);
      end
      @(negedge clk);
    end
    $display("scan: %0d samples checked", 2 * FRAME);
  endtask

  task automatic test_convert();
    int vals [3] = '{1234, 0, 9999};
    int n, bad;
    exp_t e;
    logic [3:0][6:0] segs;
    foreach (vals[k]) begin
      do_load(vals[k], n);
      e = sb_q.pop_front();
      n_checks++; if (n !== CONV_LEN) begin n_fail++; $display("FAIL conv_busy_len(%0d): got %0d want %0d", vals[k], n, CONV_LEN); end
      n_checks++; if (host_if.overflow !== e.ovf) begin n_fail++; $display("FAIL conv_ovf(%0d): got %b want %b", vals[k], host_if.overflow, e.ovf); end
      capture_frame(segs, bad);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL conv_an(%0d): %0d bad an samples, want 0", vals[k], bad); end
      for (int d = 0; d < 4; d++) begin
        n_checks++; if (segs[d] !== e.segs[d]) begin n_fail++; $display("FAIL conv_seg(%0d) digit %0d: got %b want %b", vals[k], d, segs[d], e.segs[d]); end
      end
    end
  endtask

  task automatic test_blanking();
    int vals [3] = '{7, 1000, 40};
    int n, bad;
    exp_t e;
    logic [3:0][6:0] segs;
    foreach (vals[k]) begin
      do_load(vals[k], n);
      e = sb_q.pop_front();
      n_checks++; if (n !== CONV_LEN) begin n_fail++; $display("FAIL blank_busy_len(%0d): got %0d want %0d", vals[k], n, CONV_LEN); end
      capture_frame(segs, bad);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL blank_an(%0d): %0d bad an samples, want 0", vals[k], bad); end
      for (int d = 0; d < 4; d++) begin
        n_checks++; if (segs[d] !== e.segs[d]) begin n_fail++; $display("FAIL blank_seg(%0d) digit %0d: got %b want %b", vals[k], d, segs[d], e.segs[d]); end
      end
    end
  endtask

  task automatic test_overflow();
    int vals [3] = '{12000, 5, 10000};
    int n, bad;
    exp_t e;
    logic [3:0][6:0] segs;
    foreach (vals[k]) begin
      do_load(vals[k], n);
      e = sb_q.pop_front();
      n_checks++; if (n !== CONV_LEN) begin n_fail++; $display("FAIL ovf_busy_len(%0d): got %0d want %0d", vals[k], n, CONV_LEN); end
      n_checks++; if (host_if.overflow !== e.ovf) begin n_fail++; $display("FAIL ovf_flag(%0d): got %b want %b", vals[k], host_if.overflow, e.ovf); end
      capture_frame(segs, bad);
      for (int d = 0; d < 4; d++) begin
        n_checks++; if (segs[d] !== e.segs[d]) begin n_fail++; $display("FAIL ovf_seg(%0d) digit %0d: got %b want %b", vals[k], d, segs[d], e.segs[d]); end
      end
    end
  endtask

  // Second load pulse during conversion must not be queued or captured.
  task automatic test_load_ignored();
    int n, late, bad;
    exp_t e;
    logic [3:0][6:0] segs;
    @(negedge clk);
    host_if.load  = 1'b1;
    host_if.value = DATA_W'(3456);
    sb_q.push_back(model(3456));
    @(negedge clk);
    host_if.load = 1'b0;
    n = 0;
    while (host_if.busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) begin
        host_if.load  = 1'b1;
        host_if.value = DATA_W'(42);
      end else begin
        host_if.load = 1'b0;
      end
      @(negedge clk);
    end
    host_if.load = 1'b0;
    $display("load 3456 with mid-conversion load 42: busy %0d cycles", n);
    e = sb_q.pop_front();
    n_checks++; if (n !== CONV_LEN) begin n_fail++; $display("FAIL ign_busy_len: got %0d want %0d", n, CONV_LEN); end
    late = 0;
    repeat (5) begin
      if (host_if.busy !== 1'b0) late++;
      @(negedge clk);
    end
    n_checks++; if (late !== 0) begin n_fail++; $display("FAIL ign_requeued: busy seen %0d times, want 0", late); end
    capture_frame(segs, bad);
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (segs[d] !== e.segs[d]) begin n_fail++; $display("FAIL ign_seg digit %0d: got %b want %b", d, segs[d], e.segs[d]); end
    end
  endtask

  // load held high: exactly one idle cycle between conversions.
  task automatic test_back_to_back();
    int n1, n2, bad;
    exp_t e;
    logic [3:0][6:0] segs;
    @(negedge clk);
    host_if.load  = 1'b1;
    host_if.value = DATA_W'(77);
    @(negedge clk);
    n1 = 0;
    while (host_if.busy === 1'b1 && n1 < 100) begin
      n1++;
      @(negedge clk);
    end
    host_if.value = DATA_W'(88);
    sb_q.push_back(model(88));
    @(negedge clk);
    n_checks++; if (host_if.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept: busy got %b want 1", host_if.busy); end
    host_if.load = 1'b0;
    n2 = 0;
    while (host_if.busy === 1'b1 && n2 < 100) begin
      n2++;
      @(negedge clk);
    end
    $display("back-to-back 77 then 88: busy %0d and %0d cycles", n1, n2);
    e = sb_q.pop_front();
    n_checks++; if (n1 !== CONV_LEN) begin n_fail++; $display("FAIL b2b_len1: got %0d want %0d", n1, CONV_LEN); end
    n_checks++; if (n2 !== CONV_LEN) begin n_fail++; $display("FAIL b2b_len2: got %0d want %0d", n2, CONV_LEN); end
    capture_frame(segs, bad);
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (segs[d] !== e.segs[d]) begin n_fail++; $display("FAIL b2b_seg digit %0d: got %b want %b", d, segs[d], e.segs[d]); end
    end
  endtask

  task automatic test_reset_mid();
    int n, stray, bad;
    exp_t e;
    logic [3:0][6:0] segs;
    do_load(12000, n);
    e = sb_q.pop_front();
    n_checks++; if (host_if.overflow !== e.ovf) begin n_fail++; $display("FAIL rmid_pre_ovf: got %b want %b", host_if.overflow, e.ovf); end
    @(negedge clk);
    host_if.load  = 1'b1;
    host_if.value = DATA_W'(8765);
    @(negedge clk);
    host_if.load = 1'b0;
    n = 0;
    while (host_if.busy === 1'b1 && n < 7) begin
      n++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    $display("reset asserted after %0d conversion cycles", n);
    n_checks++; if (host_if.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", host_if.busy); end
    n_checks++; if (host_if.overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf: got %b want 0", host_if.overflow); end
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL rmid_an: got %b want 1110", an); end
    n_checks++; if (seg !== 7'b0000001) begin n_fail++; $display("FAIL rmid_seg: got %b want 0000001", seg); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(model(0));
    stray = 0;
    repeat (2 * CONV_LEN) begin
      if (host_if.busy !== 1'b0 || host_if.overflow !== 1'b0) stray++;
      @(negedge clk);
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rmid_commit_after: %0d stray busy/ovf samples, want 0", stray); end
    e = sb_q.pop_front();
    capture_frame(segs, bad);
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (segs[d] !== e.segs[d]) begin n_fail++; $display("FAIL rmid_seg digit %0d: got %b want %b", d, segs[d], e.segs[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert();
    test_blanking();
    test_overflow();
    test_load_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
